fft_stage_sched: RTL and testbench
==================================

Name: fft_stage_sched

Overview:
- Sequencer for the in-place radix-2 DIT FFT butterfly array of M op units.
- For every stage, issues the sample-memory read addresses (a, b) and twiddle ROM indices for each unit.
- Tracks the butterfly and ROM pipeline latency and issues delayed write-back addresses.
- Drains between stages and reports completion to the top-level control (start/busy/done).

Parameters:
- LOGN, 12, log2 of transform length N; N = 2^LOGN.
- LOGM, 1, log2 of butterfly unit count M; requires LOGM <= LOGN-1.
- LAT, 14, cycles from rd_en to the matching write (memory read + ROM + multiply/add pipeline); LAT >= 1.
- SW, 4, stage index width; requires 2^SW >= LOGN.

Ports:
- clk_run  in  1  clock (gated run clock).
- rst  in  1  reset.
- start  in  1  begin transform; sampled only in IDLE.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle completion pulse.
- stage  out  SW  current stage index s.
- rd_en  out  1  read/issue strobe for all M units.
- rd_addr_a  out  LOGN*M  unit u at bits [u*LOGN +: LOGN].
- rd_addr_b  out  LOGN*M  same packing.
- tw_idx  out  LOGN*M  twiddle ROM address per unit, same packing.
- wr_en  out  1  write-back strobe.
- wr_addr_a  out  LOGN*M  rd_addr_a delayed by LAT.
- wr_addr_b  out  LOGN*M  rd_addr_b delayed by LAT.

Behaviour:
- Reset rst is asynchronous, active-high; clock is clk_run. Reset forces: state IDLE, all outputs 0, iter/stage/drain counters 0, delay line cleared.
- Reset mid-transform aborts immediately; no wr_en is asserted after reset.
- States:
  - IDLE -> ISSUE when start=1; stage=0, iter=0.
  - ISSUE: rd_en=1 every cycle; iter increments; after iter = N/(2M)-1 go to DRAIN with drain counter = LAT.
  - DRAIN: rd_en=0; decrement once per cycle; on the last drain cycle, if stage==LOGN-1 go to DONE, else stage+1, iter=0, go to ISSUE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- start while busy or in DONE is ignored; no queueing.
- Address generation for unit u, butterfly j = iter*M + u, stage s, half = 2^s:
  - pos = j mod half.
  - a = ((j >> s) << (s+1)) | pos.
  - b = a + half.
  - tw_idx = pos << (LOGN-1-s), i.e. W_N^k with k < N/2.
- Address outputs are registered, valid in the same cycle as rd_en, and hold their last value when rd_en=0.
- Write-back: wr_en and wr_addr_* equal rd_en and rd_addr_* exactly LAT cycles earlier.
- The drain is mandatory: the next stage's first read issues one cycle after the final write of the previous stage (read-after-write safety for in-place memory).
- Timing: start sampled at edge 0, first rd_en in cycle 1, done in cycle 1 + LOGN*(N/(2M)+LAT).
- All index arithmetic is unsigned. The iter counter width is LOGN-1-LOGM and wraps only at the stage boundary.

Decomposition:
- fft_pkg: LOGN, LOGM, M, N, LAT defaults; state encoding (IDLE, ISSUE, DRAIN, DONE); address packing helper widths.
- Sub-module fft_addr_delay: parameterised LAT-deep shift register carrying {rd_en, rd_addr_a, rd_addr_b}, with async clear on rst.

Test Plan:
- LOGN=3, LOGM=0, LAT=2, pulse start:
  - stage0 (a,b,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0).
  - stage1 = (0,2,0),(1,3,2),(4,6,0),(5,7,2).
  - stage2 = (0,4,0),(1,5,1),(2,6,2),(3,7,3).
  - done in cycle 19.
- Same config: each wr_en/wr_addr pair matches the rd pair from exactly 2 cycles earlier; 2 idle cycles between stages; no rd_en overlaps a pending write of the previous stage.
- LOGN=4, LOGM=1, LAT=3, stage 3:
  - first issue gives unit0 (0,8,tw0), unit1 (1,9,tw1).
  - done in cycle 1+4*(4+3)=29.
- Start held high throughout: exactly one transform runs until done; a new one begins only from IDLE, on the cycle after the done pulse returns the block to IDLE.
- Assert rst in stage 1 mid-ISSUE: all outputs 0 immediately (asynchronously); no wr_en in the following LAT cycles; a later start runs a full correct transform.
- LOGN=12, LOGM=1, LAT=14: busy high for exactly 12*(1024+14) cycles; done pulses once; final tw_idx for unit1 = 2047.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the FFT stage scheduler.
package fft_pkg;

    localparam int LOGN_DEF = 12;
    localparam int LOGM_DEF = 1;
    localparam int LAT_DEF  = 14;
    localparam int SW_DEF   = 4;
    localparam int M_DEF    = 1 << LOGM_DEF;
    localparam int N_DEF    = 1 << LOGN_DEF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Iteration counter needs LOGN-1-LOGM bits; keep at least one bit so the
    // degenerate single-iteration case still elaborates.
    function automatic int iter_w(input int logn, input int logm);
        return (logn - 1 - logm > 0) ? (logn - 1 - logm) : 1;
    endfunction

    function automatic int cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

    function automatic int addr_w(input int logn, input int logm);
        return logn << logm;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// LAT-deep shift register that turns the read strobe/addresses into the
// matching write-back strobe/addresses.
module fft_addr_delay
    import fft_pkg::*;
#(
    parameter int LAT = LAT_DEF,
    parameter int W   = 24
) (
    input  logic         clk_run,
    input  logic         rst,
    input  logic         vld_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         vld_o,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    logic [LAT-1:0]        vld_pipe_q;
    logic [LAT-1:0][W-1:0] a_pipe_q;
    logic [LAT-1:0][W-1:0] b_pipe_q;

    // Clearing the valid bits on reset guarantees no stale write-back escapes
    // after an aborted transform.
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            a_pipe_q   <= '0;
            b_pipe_q   <= '0;
        end else begin
            vld_pipe_q[0] <= vld_i;
            a_pipe_q[0]   <= a_i;
            b_pipe_q[0]   <= b_i;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                a_pipe_q[i]   <= a_pipe_q[i-1];
                b_pipe_q[i]   <= b_pipe_q[i-1];
            end
        end
    end

    assign vld_o = vld_pipe_q[LAT-1];
    assign a_o   = a_pipe_q[LAT-1];
    assign b_o   = b_pipe_q[LAT-1];

endmodule

// File: rtl/fft_stage_sched.sv
// Stage sequencer for an in-place radix-2 DIT FFT with M butterfly units:
// issues read/twiddle addresses per stage, drains the pipeline, then writes back.
module fft_stage_sched
    import fft_pkg::*;
#(
    parameter int LOGN = LOGN_DEF,
    parameter int LOGM = LOGM_DEF,
    parameter int LAT  = LAT_DEF,
    parameter int SW   = SW_DEF
) (
    input  logic                    clk_run,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [SW-1:0]           stage,
    output logic                    rd_en,
    output logic [(LOGN<<LOGM)-1:0] rd_addr_a,
    output logic [(LOGN<<LOGM)-1:0] rd_addr_b,
    output logic [(LOGN<<LOGM)-1:0] tw_idx,
    output logic                    wr_en,
    output logic [(LOGN<<LOGM)-1:0] wr_addr_a,
    output logic [(LOGN<<LOGM)-1:0] wr_addr_b
);

    localparam int M  = 1 << LOGM;
    localparam int N  = 1 << LOGN;
    localparam int AW = addr_w(LOGN, LOGM);
    localparam int IW = iter_w(LOGN, LOGM);
    localparam int CW = cnt_w(LAT);

    localparam logic [IW-1:0] ITER_LAST  = IW'(N / (2 * M) - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOGN - 1);
    localparam logic [CW-1:0] DRAIN_INIT = CW'(LAT);

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [CW-1:0] drain_q, drain_d;
    logic          rd_en_q, busy_q, done_q;
    logic [AW-1:0] addr_a_q, addr_b_q, tw_q;
    logic [AW-1:0] addr_a_d, addr_b_d, tw_d;
    logic          issue_d;

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        stage_d = stage_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    iter_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (iter_q == ITER_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end else begin
                    iter_d = iter_q + IW'(1);
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - CW'(1);
                // Last drain cycle coincides with the final write of this stage.
                if (drain_q == CW'(1)) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + SW'(1);
                        iter_d  = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign issue_d = (state_d == ST_ISSUE);

    // Addresses are computed from next-state iter/stage so the registered
    // outputs line up with the registered rd_en.
    logic [SW:0]     sh_hi;
    logic [SW-1:0]   sh_tw;
    logic [LOGN-1:0] half_d, hmask_d;

    assign sh_hi   = {1'b0, stage_d} + (SW+1)'(1);
    assign sh_tw   = STAGE_LAST - stage_d;
    assign half_d  = LOGN'(1) << stage_d;
    assign hmask_d = half_d - LOGN'(1);

    for (genvar u = 0; u < M; u++) begin : g_unit
        logic [LOGN-1:0] j, pos, a;
        assign j   = (LOGN'(iter_d) << LOGM) | LOGN'(u);
        assign pos = j & hmask_d;
        assign a   = ((j >> stage_d) << sh_hi) | pos;
        assign addr_a_d[u*LOGN +: LOGN] = a;
        assign addr_b_d[u*LOGN +: LOGN] = a | half_d;
        assign tw_d[u*LOGN +: LOGN]     = pos << sh_tw;
    end

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            iter_q   <= '0;
            stage_q  <= '0;
            drain_q  <= '0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            rd_en_q <= issue_d;
            busy_q  <= (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
            done_q  <= (state_d == ST_DONE);
            if (issue_d) begin
                addr_a_q <= addr_a_d;
                addr_b_q <= addr_b_d;
                tw_q     <= tw_d;
            end
        end
    end

    fft_addr_delay #(
        .LAT (LAT),
        .W   (AW)
    ) u_delay (
        .clk_run (clk_run),
        .rst     (rst),
        .vld_i   (rd_en_q),
        .a_i     (addr_a_q),
        .b_i     (addr_b_q),
        .vld_o   (wr_en),
        .a_o     (wr_addr_a),
        .b_o     (wr_addr_b)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = stage_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = addr_a_q;
    assign rd_addr_b = addr_b_q;
    assign tw_idx    = tw_q;

endmodule

// File: tb/tb_fft_stage_sched.sv
// Scoreboard bench for fft_stage_sched in three configurations with
// hand-computed address tables and cycle numbers.
module tb_fft_stage_sched;

    logic clk_run = 1'b0;
    logic rst     = 1'b0;
    logic start0  = 1'b0;
    logic start1  = 1'b0;
    logic start2  = 1'b0;

    always #5 clk_run = ~clk_run;

    // d0: LOGN=3 LOGM=0 LAT=2
    logic       busy0, done0, rd_en0, wr_en0;
    logic [3:0] stage0;
    logic [2:0] ra0, rb0, tw0, wa0, wb0;
    // d1: LOGN=4 LOGM=1 LAT=3
    logic       busy1, done1, rd_en1, wr_en1;
    logic [3:0] stage1;
    logic [7:0] ra1, rb1, tw1, wa1, wb1;
    // d2: LOGN=12 LOGM=1 LAT=14
    logic        busy2, done2, rd_en2, wr_en2;
    logic [3:0]  stage2;
    logic [23:0] ra2, rb2, tw2, wa2, wb2;

    fft_stage_sched #(.LOGN(3), .LOGM(0), .LAT(2), .SW(4)) d0 (
        .clk_run(clk_run), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .stage(stage0), .rd_en(rd_en0), .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_idx(tw0),
        .wr_en(wr_en0), .wr_addr_a(wa0), .wr_addr_b(wb0));

    fft_stage_sched #(.LOGN(4), .LOGM(1), .LAT(3), .SW(4)) d1 (
        .clk_run(clk_run), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .stage(stage1), .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_idx(tw1),
        .wr_en(wr_en1), .wr_addr_a(wa1), .wr_addr_b(wb1));

    fft_stage_sched #(.LOGN(12), .LOGM(1), .LAT(14), .SW(4)) d2 (
        .clk_run(clk_run), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .stage(stage2), .rd_en(rd_en2), .rd_addr_a(ra2), .rd_addr_b(rb2), .tw_idx(tw2),
        .wr_en(wr_en2), .wr_addr_a(wa2), .wr_addr_b(wb2));

    typedef struct packed {
        int cyc; int st;
        int a0; int b0; int t0;
        int a1; int b1; int t1;
    } rd_t;

    rd_t rq0[$], wq0[$], dq0[$], rq1[$], dq1[$], dq2[$];

    int errors   = 0;
    int checks   = 0;
    int edge_cnt = 0;
    int busy_cnt2 = 0;
    int done_cnt2 = 0;

    // Hand table for N=8, M=1: stage0, stage1, stage2 butterflies in issue order.
    int ea [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int eb [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int et [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    always @(posedge clk_run) edge_cnt <= edge_cnt + 1;

    function automatic rd_t mk(input int c, input int s, input int a0, input int b0,
                               input int t0, input int a1, input int b1, input int t1);
        rd_t r;
        r.cyc = c; r.st = s;
        r.a0 = a0; r.b0 = b0; r.t0 = t0;
        r.a1 = a1; r.b1 = b1; r.t1 = t1;
        return r;
    endfunction

    task automatic report(input string nm, input rd_t act, input rd_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cyc=%0d st=%0d u0=(%0d,%0d,%0d) u1=(%0d,%0d,%0d) want cyc=%0d st=%0d u0=(%0d,%0d,%0d) u1=(%0d,%0d,%0d)",
                     nm, act.cyc, act.st, act.a0, act.b0, act.t0, act.a1, act.b1, act.t1,
                     exp.cyc, exp.st, exp.a0, exp.b0, exp.t0, exp.a1, exp.b1, exp.t1);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at edge %0d, want none", nm, edge_cnt);
    endtask

    // b = edge count right after the start-sampling edge; cycle c sits at b+c-1.
    task automatic push0(input int b);
        for (int k = 0; k < 12; k++) begin
            int c;
            c = b + (k / 4) * 6 + (k % 4);
            rq0.push_back(mk(c, k / 4, ea[k], eb[k], et[k], 0, 0, 0));
            wq0.push_back(mk(c + 2, 0, ea[k], eb[k], 0, 0, 0, 0));
        end
        dq0.push_back(mk(b + 18, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic wait_done(input int which, input int lim);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < lim) begin
            @(negedge clk_run);
            n++;
            seen = (which == 0) ? done0 : (which == 1) ? done1 : done2;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_d%0d: done not seen within %0d cycles, want a done pulse", which, lim);
        end
    endtask

    // Monitors: pop an expectation whenever a DUT presents an event.
    always @(negedge clk_run) begin : mon0
        if (!rst) begin
            if (rd_en0) begin
                if (rq0.size() == 0) unexpected("rd0");
                else report("rd0", mk(edge_cnt, int'(stage0), int'(ra0), int'(rb0), int'(tw0), 0, 0, 0), rq0.pop_front());
            end
            if (wr_en0) begin
                if (wq0.size() == 0) unexpected("wr0");
                else report("wr0", mk(edge_cnt, 0, int'(wa0), int'(wb0), 0, 0, 0, 0), wq0.pop_front());
            end
            if (done0) begin
                if (dq0.size() == 0) unexpected("done0");
                else report("done0", mk(edge_cnt, 0, 0, 0, 0, 0, 0, 0), dq0.pop_front());
            end
        end
    end

    always @(negedge clk_run) begin : mon1
        if (!rst) begin
            if (rd_en1 && stage1 == 4'd3) begin
                if (rq1.size() == 0) unexpected("rd1");
                else report("rd1_s3", mk(edge_cnt, int'(stage1), int'(ra1[3:0]), int'(rb1[3:0]), int'(tw1[3:0]),
                                         int'(ra1[7:4]), int'(rb1[7:4]), int'(tw1[7:4])), rq1.pop_front());
            end
            if (done1) begin
                if (dq1.size() == 0) unexpected("done1");
                else report("done1", mk(edge_cnt, 0, 0, 0, 0, 0, 0, 0), dq1.pop_front());
            end
        end
    end

    always @(negedge clk_run) begin : mon2
        if (!rst) begin
            if (busy2) busy_cnt2++;
            if (done2) begin
                done_cnt2++;
                if (dq2.size() == 0) unexpected("done2");
                else report("done2", mk(edge_cnt, 0, 0, 0, 0, 0, 0, 0), dq2.pop_front());
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int b;
        int n;

        // Reset state
        rst = 1'b1;
        #12;
        chk_int("reset_d0", int'({busy0, done0, stage0, rd_en0, ra0, rb0, tw0, wr_en0, wa0, wb0}), 0);
        chk_int("reset_d2", int'({busy2, done2, rd_en2, wr_en2, stage2}), 0);
        rst = 1'b0;

        // Single pulse: full N=8 transform
        @(negedge clk_run); start0 = 1'b1;
        @(posedge clk_run); #1 b = edge_cnt; start0 = 1'b0;
        push0(b);
        wait_done(0, 60);
        repeat (3) @(negedge clk_run);
        chk_int("pulse_drained", rq0.size() + wq0.size() + dq0.size(), 0);
        chk_int("pulse_idle_busy", int'(busy0), 0);

        // Start held high: second run starts from IDLE one cycle after done
        @(negedge clk_run); start0 = 1'b1;
        @(posedge clk_run); #1 b = edge_cnt;
        push0(b);
        push0(b + 20);
        wait_done(0, 60);
        repeat (5) @(negedge clk_run);
        start0 = 1'b0;
        wait_done(0, 60);
        repeat (4) @(negedge clk_run);
        chk_int("held_drained", rq0.size() + wq0.size() + dq0.size(), 0);
        chk_int("held_idle_busy", int'(busy0), 0);

        // Reset in stage 1 mid-issue
        @(negedge clk_run); start0 = 1'b1;
        @(posedge clk_run); #1 b = edge_cnt; start0 = 1'b0;
        push0(b);
        n = 0;
        while (!(rd_en0 && stage0 == 4'd1) && n < 40) begin
            @(negedge clk_run);
            n++;
        end
        chk_int("reached_stage1", int'(rd_en0 && stage0 == 4'd1), 1);
        @(posedge clk_run); #2 rst = 1'b1;
        #1;
        chk_int("async_reset_outs", int'({busy0, done0, stage0, rd_en0, ra0, rb0, tw0, wr_en0, wa0, wb0}), 0);
        rq0.delete(); wq0.delete(); dq0.delete();
        n = 0;
        repeat (2) begin @(negedge clk_run); if (wr_en0) n++; end
        @(posedge clk_run); #3 rst = 1'b0;
        repeat (3) begin @(negedge clk_run); if (wr_en0) n++; end
        chk_int("no_wr_after_rst", n, 0);

        @(negedge clk_run); start0 = 1'b1;
        @(posedge clk_run); #1 b = edge_cnt; start0 = 1'b0;
        push0(b);
        wait_done(0, 60);
        repeat (3) @(negedge clk_run);
        chk_int("post_rst_drained", rq0.size() + wq0.size() + dq0.size(), 0);

        // d1 (stage 3 table, done cycle 29) and d2 (full size) together
        @(negedge clk_run); start1 = 1'b1; start2 = 1'b1;
        @(posedge clk_run); #1 b = edge_cnt; start1 = 1'b0; start2 = 1'b0;
        for (int i = 0; i < 4; i++)
            rq1.push_back(mk(b + 21 + i, 3, 2*i, 2*i + 8, 2*i, 2*i + 1, 2*i + 9, 2*i + 1));
        dq1.push_back(mk(b + 28, 0, 0, 0, 0, 0, 0, 0));
        dq2.push_back(mk(b + 12456, 0, 0, 0, 0, 0, 0, 0));
        wait_done(1, 60);
        wait_done(2, 13000);
        repeat (3) @(negedge clk_run);
        chk_int("d1_drained", rq1.size() + dq1.size(), 0);
        chk_int("d2_busy_cycles", busy_cnt2, 12456);
        chk_int("d2_done_pulses", done_cnt2, 1);
        chk_int("d2_final_tw_u1", int'(tw2[23:12]), 2047);
        chk_int("d2_final_tw_u0", int'(tw2[11:0]), 2046);
        chk_int("d2_final_a_u1", int'(ra2[23:12]), 2047);
        chk_int("d2_final_b_u1", int'(rb2[23:12]), 4095);
        chk_int("d2_drained", dq2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
